// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic MAC array and its operand
//                feeder: feeder FSM encoding and default array geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Default array geometry shared with the MAC array
    localparam int ARR_SIZE_DEF      = 4;
    localparam int HORIZONTAL_BW_DEF = 16;
    localparam int VERTICAL_BW_DEF   = 16;

    // Feeder sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feeder_state_t;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/systolic_skew_feeder_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module      : skew_lane
//  Description : One operand lane of the skew feeder. Holds ARR_SIZE operands
//                and presents element (t - LANE_IDX) when that index is inside
//                the tile, otherwise zero. The selection is combinational; the
//                parent registers it.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_lane #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int LANE_IDX = 0,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  t,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [CNT_W-1:0] c_lane = CNT_W'(LANE_IDX);
    localparam logic [CNT_W-1:0] c_size = CNT_W'(ARR_SIZE);

    // Tile storage has no reset: its contents are only read after a full load
    logic [DATA_W-1:0] r_mem [ARR_SIZE];
    logic [CNT_W-1:0]  w_rel;

    assign w_rel = t - c_lane;

    // Capture one operand per accepted load beat
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // Skewed element select: zero before this lane's wavefront arrives and after it passes
    always_comb begin
        data_out = '0;
        if ((t >= c_lane) && (w_rel < c_size)) begin
            data_out = r_mem[w_rel[IDX_W-1:0]];
        end
    end

endmodule : skew_lane
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : Buffers one ARR_SIZE x ARR_SIZE tile of A (column beats) and
//                B (row beats), then streams them diagonally skewed onto the
//                MAC array's horizontal/vertical buses, followed by a zero
//                drain period and a one-cycle done pulse.
//                Optional macro FEEDER_TILE_CNT_EN adds a 16-bit tile_cnt
//                output counting completed tiles.
//                ARR_SIZE must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int ARR_SIZE      = ARR_SIZE_DEF,
    parameter int HORIZONTAL_BW = HORIZONTAL_BW_DEF,
    parameter int DRAIN_CYCLES  = 2*ARR_SIZE+1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] wr_a,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] wr_b,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] horiz_out,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] vert_out,
    output logic                        feed_valid,
    output logic                        busy,
    output logic                        done
`ifdef FEEDER_TILE_CNT_EN
    ,
    output logic [15:0]                 tile_cnt
`endif
);

    localparam int c_cnt_w = $clog2(2*ARR_SIZE+DRAIN_CYCLES) + 1;
    localparam int c_idx_w = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;

    localparam logic [c_idx_w-1:0] c_k_last     = c_idx_w'(ARR_SIZE-1);
    localparam logic [c_cnt_w-1:0] c_stream_end = c_cnt_w'(2*ARR_SIZE-1);
    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_CYCLES-1);

    feeder_state_t                      r_state;
    logic [c_idx_w-1:0]                 r_k;
    logic [c_cnt_w-1:0]                 r_t;
    logic                               w_accept;
    logic [ARR_SIZE*HORIZONTAL_BW-1:0]  w_horiz;
    logic [ARR_SIZE*HORIZONTAL_BW-1:0]  w_vert;

    // Ready is withheld in the done cycle so the next tile starts one cycle later
    assign wr_ready = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !done;
    assign w_accept = wr_valid && wr_ready;

    // Lane i of each bus selects element t-i of its stored operand column/row
    for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
        skew_lane #(
            .ARR_SIZE (ARR_SIZE),
            .DATA_W   (HORIZONTAL_BW),
            .LANE_IDX (g),
            .IDX_W    (c_idx_w),
            .CNT_W    (c_cnt_w)
        ) u_a_lane (
            .clk      (clk),
            .wr_en    (w_accept),
            .wr_idx   (r_k),
            .wr_data  (wr_a[g*HORIZONTAL_BW +: HORIZONTAL_BW]),
            .t        (r_t),
            .data_out (w_horiz[g*HORIZONTAL_BW +: HORIZONTAL_BW])
        );

        skew_lane #(
            .ARR_SIZE (ARR_SIZE),
            .DATA_W   (HORIZONTAL_BW),
            .LANE_IDX (g),
            .IDX_W    (c_idx_w),
            .CNT_W    (c_cnt_w)
        ) u_b_lane (
            .clk      (clk),
            .wr_en    (w_accept),
            .wr_idx   (r_k),
            .wr_data  (wr_b[g*HORIZONTAL_BW +: HORIZONTAL_BW]),
            .t        (r_t),
            .data_out (w_vert[g*HORIZONTAL_BW +: HORIZONTAL_BW])
        );
    end

    // Sequencer: r_t holds the index of the next stream step to present, so the
    // edge accepting the last beat already registers the t=0 wavefront.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_t        <= '0;
            horiz_out  <= '0;
            vert_out   <= '0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_k     <= r_k + 1'b1;
                        busy    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_k == c_k_last) begin
                            r_k        <= '0;
                            r_t        <= r_t + 1'b1;
                            horiz_out  <= w_horiz;
                            vert_out   <= w_vert;
                            feed_valid <= 1'b1;
                            r_state    <= ST_STREAM;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (r_t == c_stream_end) begin
                        r_t        <= '0;
                        horiz_out  <= '0;
                        vert_out   <= '0;
                        feed_valid <= 1'b0;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_t       <= r_t + 1'b1;
                        horiz_out <= w_horiz;
                        vert_out  <= w_vert;
                    end
                end
                ST_DRAIN: begin
                    if (r_t == c_drain_last) begin
                        r_t     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_TILE_CNT_EN
    // Completed-tile counter, advancing on the same edge that raises done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt <= '0;
        end else if ((r_state == ST_DRAIN) && (r_t == c_drain_last)) begin
            tile_cnt <= tile_cnt + 16'd1;
        end
    end
`endif

endmodule : systolic_skew_feeder
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Directed, table-driven bench for systolic_skew_feeder with
//                ARR_SIZE=4, HORIZONTAL_BW=16, DRAIN_CYCLES=9.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int BW = 16;
    localparam int DR = 2*N+1;
    localparam int NCYC = (2*N-1) + DR + 1;   // stream + drain + done cycle

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [N*BW-1:0] wr_a;
    logic [N*BW-1:0] wr_b;
    logic [N*BW-1:0] horiz_out;
    logic [N*BW-1:0] vert_out;
    logic            feed_valid;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N*BW-1:0] horiz;
        logic [N*BW-1:0] vert;
        logic            fv;
        logic            busy;
        logic            done;
        logic            rdy;
    } vec_t;

    vec_t tbl [NCYC];

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .ARR_SIZE      (N),
        .HORIZONTAL_BW (BW),
        .DRAIN_CYCLES  (DR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_a       (wr_a),
        .wr_b       (wr_b),
        .horiz_out  (horiz_out),
        .vert_out   (vert_out),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N*BW-1:0] act, input logic [N*BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present nbeats load beats; gapped inserts an idle cycle before each later beat
    task automatic load_tile(input bit gapped, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            if (gapped && k > 0) begin
                wr_valid = 1'b0;
                step();
                chk("gap_ready", {63'd0, wr_ready}, 64'd1);
                chk("gap_busy", {63'd0, busy}, 64'd1);
            end
            for (int i = 0; i < N; i++) begin
                wr_a[i*BW +: BW] = 16'(16*i + k);
                wr_b[i*BW +: BW] = 16'(256 + 16*k + i);
            end
            wr_valid = 1'b1;
            chk($sformatf("load_ready_k%0d", k), {63'd0, wr_ready}, 64'd1);
            step();
            if (k < N-1) begin
                chk($sformatf("load_busy_k%0d", k), {63'd0, busy}, 64'd1);
                chk($sformatf("load_fv_k%0d", k), {63'd0, feed_valid}, 64'd0);
            end
        end
        wr_valid = 1'b0;
    endtask

    // Compare the full stream/drain/done sequence against the table
    task automatic run_stream(input bit hold, input string tag);
        wr_valid = hold;
        if (hold) begin
            wr_a = 64'hDEAD_BEEF_DEAD_BEEF;
            wr_b = 64'hBAD0_BAD1_BAD2_BAD3;
        end
        for (int c = 0; c < NCYC; c++) begin
            chk($sformatf("%s_horiz_c%0d", tag, c), horiz_out, tbl[c].horiz);
            chk($sformatf("%s_vert_c%0d", tag, c), vert_out, tbl[c].vert);
            chk($sformatf("%s_fv_c%0d", tag, c), {63'd0, feed_valid}, {63'd0, tbl[c].fv});
            chk($sformatf("%s_busy_c%0d", tag, c), {63'd0, busy}, {63'd0, tbl[c].busy});
            chk($sformatf("%s_done_c%0d", tag, c), {63'd0, done}, {63'd0, tbl[c].done});
            chk($sformatf("%s_rdy_c%0d", tag, c), {63'd0, wr_ready}, {63'd0, tbl[c].rdy});
            step();
        end
        wr_valid = 1'b0;
        chk({tag, "_done_width"}, {63'd0, done}, 64'd0);
        chk({tag, "_rdy_after"}, {63'd0, wr_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*BW-1:0] hv [2*N-1];
        logic [N*BW-1:0] vv [2*N-1];

        // Hand-computed wavefronts: A[i][k]=0x10*i+k, B[k][j]=0x100+0x10*k+j
        hv = '{64'h0000_0000_0000_0000, 64'h0000_0000_0010_0001,
               64'h0000_0020_0011_0002, 64'h0030_0021_0012_0003,
               64'h0031_0022_0013_0000, 64'h0032_0023_0000_0000,
               64'h0033_0000_0000_0000};
        vv = '{64'h0000_0000_0000_0100, 64'h0000_0000_0101_0110,
               64'h0000_0102_0111_0120, 64'h0103_0112_0121_0130,
               64'h0113_0122_0131_0000, 64'h0123_0132_0000_0000,
               64'h0133_0000_0000_0000};
        for (int c = 0; c < NCYC; c++) begin
            if (c < 2*N-1) begin
                tbl[c] = '{horiz: hv[c], vert: vv[c], fv: 1'b1, busy: 1'b1, done: 1'b0, rdy: 1'b0};
            end else if (c < NCYC-1) begin
                tbl[c] = '{horiz: '0, vert: '0, fv: 1'b0, busy: 1'b1, done: 1'b0, rdy: 1'b0};
            end else begin
                tbl[c] = '{horiz: '0, vert: '0, fv: 1'b0, busy: 1'b0, done: 1'b1, rdy: 1'b0};
            end
        end

        // Reset state
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_a     = '0;
        wr_b     = '0;
        step();
        step();
        chk("rst_horiz", horiz_out, 64'd0);
        chk("rst_vert", vert_out, 64'd0);
        chk("rst_fv", {63'd0, feed_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rdy", {63'd0, wr_ready}, 64'd1);
        rst = 1'b0;
        step();

        // Back-to-back load
        load_tile(1'b0, N);
        run_stream(1'b0, "b2b");

        // Valid held through stream/drain, then a normal tile
        load_tile(1'b0, N);
        run_stream(1'b1, "hold");
        load_tile(1'b0, N);
        run_stream(1'b0, "after_hold");

        // Gapped load
        load_tile(1'b1, N);
        run_stream(1'b0, "gap");

        // Asynchronous reset pulse mid-stream (no clock edge while asserted)
        load_tile(1'b0, N);
        step();
        step();
        step();
        chk("pre_rst_fv", {63'd0, feed_valid}, 64'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("async_rst_horiz", horiz_out, 64'd0);
        step();
        chk("midrst_horiz", horiz_out, 64'd0);
        chk("midrst_vert", vert_out, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_fv", {63'd0, feed_valid}, 64'd0);
        chk("midrst_rdy", {63'd0, wr_ready}, 64'd1);

        // Reset during a partial load discards it
        load_tile(1'b0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("partrst_busy", {63'd0, busy}, 64'd0);
        step();
        load_tile(1'b0, N);
        run_stream(1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_systolic_skew_feeder
`default_nettype wire
